// File: rtl/busca_instrucao.sv
// Instruction fetch: req/ack fetch from instruction memory, valid/ready hand-off to decode, next-PC compute.
// Latency: 1 cycle from entering REQ with zero-wait memory to instr_valid; each memory wait cycle adds one.
// Backpressure: instr_ready low holds CHEIO (instr stable, no new request); an issued request is never withdrawn.
module busca_instrucao #(
    parameter int LARGURA = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] atual_Pc,
    output logic [LARGURA-1:0] proximo_Pc,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [LARGURA-1:0] mem_rdata,
    input  logic               desvio,
    input  logic [LARGURA-1:0] alvo_desvio,
    output logic               instr_valid,
    output logic [LARGURA-1:0] instr,
    output logic [LARGURA-1:0] instr_pc,
    input  logic               instr_ready,
    output logic               falha_alinhamento
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        CHEIO    = 3'd2,
        DESCARTA = 3'd3,
        ERRO     = 3'd4
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] instr_q, instr_d;
    logic [LARGURA-1:0] instr_pc_q, instr_pc_d;
    logic [LARGURA-1:0] end_pendente_q, end_pendente_d;
    logic               alinhado;

    assign alinhado = (atual_Pc[1:0] == 2'b00);

    always_comb begin
        estado_d       = estado_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        end_pendente_d = end_pendente_q;
        proximo_Pc     = atual_Pc;
        case (estado_q)
            IDLE: estado_d = REQ;
            REQ: begin
                if (!alinhado) begin
                    estado_d = ERRO;
                end else if (mem_ack && !desvio) begin
                    instr_d    = mem_rdata;
                    instr_pc_d = atual_Pc;
                    proximo_Pc = atual_Pc + LARGURA'(4);
                    estado_d   = CHEIO;
                end else if (mem_ack && desvio) begin
                    estado_d = REQ;
                end else if (desvio) begin
                    // The in-flight request must still complete at its original address.
                    end_pendente_d = atual_Pc;
                    estado_d       = DESCARTA;
                end
            end
            DESCARTA: if (mem_ack) estado_d = REQ;
            CHEIO:    if (instr_ready || desvio) estado_d = REQ;
            ERRO:     if (desvio) estado_d = REQ;
            default:  estado_d = IDLE;
        endcase
        if (desvio) proximo_Pc = alvo_desvio;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q       <= IDLE;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            end_pendente_q <= '0;
        end else begin
            estado_q       <= estado_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            end_pendente_q <= end_pendente_d;
        end
    end

    assign mem_req           = ((estado_q == REQ) && alinhado) || (estado_q == DESCARTA);
    assign mem_addr          = (estado_q == DESCARTA) ? end_pendente_q : atual_Pc;
    assign instr_valid       = (estado_q == CHEIO);
    assign falha_alinhamento = (estado_q == ERRO);
    assign instr             = instr_q;
    assign instr_pc          = instr_pc_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: a local pc register closes the loop; per-cycle directed vectors plus a reset-mid-request sequence.
module tb_busca_instrucao;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] atual_Pc;
    logic [31:0] proximo_Pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        desvio = 1'b0;
    logic [31:0] alvo_desvio = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        falha_alinhamento;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) atual_Pc <= '0;
        else        atual_Pc <= proximo_Pc;
    end

    busca_instrucao #(.LARGURA(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .atual_Pc         (atual_Pc),
        .proximo_Pc       (proximo_Pc),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .desvio           (desvio),
        .alvo_desvio      (alvo_desvio),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_ready      (instr_ready),
        .falha_alinhamento(falha_alinhamento)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        dsv;
        logic [31:0] alvo;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_prox;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_falha;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic ack, input logic [31:0] rdata, input logic dsv, input logic [31:0] alvo,
                     input logic rdy, input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_prox,
                     input logic e_vld, input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_falha);
        vec_t t;
        t.ack = ack; t.rdata = rdata; t.dsv = dsv; t.alvo = alvo; t.rdy = rdy;
        t.e_req = e_req; t.e_addr = e_addr; t.e_prox = e_prox; t.e_vld = e_vld;
        t.e_instr = e_instr; t.e_ipc = e_ipc; t.e_falha = e_falha;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp, input int ciclo);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nome, ciclo, got, exp);
        end
    endtask

    task automatic chk_all(input int c, input logic req, input logic [31:0] addr, input logic [31:0] prox,
                           input logic vld, input logic [31:0] ins, input logic [31:0] ipc, input logic falha);
        chk("mem_req", {31'b0, mem_req}, {31'b0, req}, c);
        chk("mem_addr", mem_addr, addr, c);
        chk("proximo_Pc", proximo_Pc, prox, c);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, vld}, c);
        chk("instr", instr, ins, c);
        chk("instr_pc", instr_pc, ipc, c);
        chk("falha_alinhamento", {31'b0, falha_alinhamento}, {31'b0, falha}, c);
    endtask

    initial begin
        //  ack rdata          dsv alvo          rdy  req addr          prox          vld instr         ipc           falha
        // zero-wait fetches at 0, 4, 8
        v(0, 32'h0,          0, 32'h0,       1,   0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0); // c0 IDLE
        v(1, 32'hA0,         0, 32'h0,       1,   1, 32'h0,        32'h4,        0, 32'h0,        32'h0,        0); // c1
        v(0, 32'h0,          0, 32'h0,       1,   0, 32'h4,        32'h4,        1, 32'hA0,       32'h0,        0);
        v(1, 32'hA4,         0, 32'h0,       1,   1, 32'h4,        32'h8,        0, 32'hA0,       32'h0,        0);
        v(0, 32'h0,          0, 32'h0,       1,   0, 32'h8,        32'h8,        1, 32'hA4,       32'h4,        0);
        v(1, 32'hA8,         0, 32'h0,       1,   1, 32'h8,        32'hC,        0, 32'hA4,       32'h4,        0);
        // decode stalls 5 cycles in CHEIO
        for (int i = 0; i < 5; i++)
            v(0, 32'h0,      0, 32'h0,       0,   0, 32'hC,        32'hC,        1, 32'hA8,       32'h8,        0);
        v(0, 32'h0,          0, 32'h0,       1,   0, 32'hC,        32'hC,        1, 32'hA8,       32'h8,        0);
        v(1, 32'hAC,         0, 32'h0,       1,   1, 32'hC,        32'h10,       0, 32'hA8,       32'h8,        0);
        v(0, 32'h0,          0, 32'h0,       1,   0, 32'h10,       32'h10,       1, 32'hAC,       32'hC,        0);
        // three wait cycles at 0x10
        for (int i = 0; i < 3; i++)
            v(0, 32'h0,      0, 32'h0,       1,   1, 32'h10,       32'h10,       0, 32'hAC,       32'hC,        0);
        v(1, 32'hB0,         0, 32'h0,       1,   1, 32'h10,       32'h14,       0, 32'hAC,       32'hC,        0);
        // redirect in CHEIO with handshake, then redirect while request at 0x20 pending
        v(0, 32'h0,          1, 32'h20,      1,   0, 32'h14,       32'h20,       1, 32'hB0,       32'h10,       0);
        v(0, 32'h0,          0, 32'h0,       1,   1, 32'h20,       32'h20,       0, 32'hB0,       32'h10,       0);
        v(0, 32'h0,          1, 32'h100,     1,   1, 32'h20,       32'h100,      0, 32'hB0,       32'h10,       0);
        v(0, 32'h0,          0, 32'h0,       1,   1, 32'h20,       32'h100,      0, 32'hB0,       32'h10,       0);
        v(1, 32'hDEAD,       0, 32'h0,       1,   1, 32'h20,       32'h100,      0, 32'hB0,       32'h10,       0);
        v(1, 32'h11110000,   0, 32'h0,       1,   1, 32'h100,      32'h104,      0, 32'hB0,       32'h10,       0);
        // misaligned redirect -> ERRO, recovered by redirect to 0x200
        v(0, 32'h0,          1, 32'h102,     0,   0, 32'h104,      32'h102,      1, 32'h11110000, 32'h100,      0);
        v(0, 32'h0,          0, 32'h0,       0,   0, 32'h102,      32'h102,      0, 32'h11110000, 32'h100,      0);
        v(1, 32'hBAD0,       0, 32'h0,       0,   0, 32'h102,      32'h102,      0, 32'h11110000, 32'h100,      1);
        v(0, 32'h0,          1, 32'h200,     0,   0, 32'h102,      32'h200,      0, 32'h11110000, 32'h100,      1);
        v(1, 32'h22220000,   0, 32'h0,       1,   1, 32'h200,      32'h204,      0, 32'h11110000, 32'h100,      0);
        v(0, 32'h0,          0, 32'h0,       1,   0, 32'h204,      32'h204,      1, 32'h22220000, 32'h200,      0);
        v(0, 32'h0,          0, 32'h0,       1,   1, 32'h204,      32'h204,      0, 32'h22220000, 32'h200,      0);

        // reset state
        repeat (2) @(negedge clk);
        #1 chk_all(-1, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            mem_ack     = vecs[i].ack;
            mem_rdata   = vecs[i].rdata;
            desvio      = vecs[i].dsv;
            alvo_desvio = vecs[i].alvo;
            instr_ready = vecs[i].rdy;
            #1 chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_prox, vecs[i].e_vld,
                       vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_falha);
            @(negedge clk);
        end

        // reset while a request at 0x204 is outstanding, response arrives after release
        mem_ack = 1'b0; desvio = 1'b0; instr_ready = 1'b1;
        #1 chk("pre_reset_req", {31'b0, mem_req}, 32'h1, 900);
        rst_n = 1'b0;
        #1 chk_all(901, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        #1 chk_all(902, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk_all(903, 1, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        #1 chk_all(904, 1, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
